convert_64_8: RTL

//   Serializer, 64-bit word to 8-bit byte stream: the transmit-side counterpart of the
//   8->64 byte packer. Accepts one 64-bit word on a valid/ready input handshake. Emits it
//   as 8 consecutive bytes on a valid/ready output handshake. Sits between a 64-bit

---
 rtl/convert_64_8_if.sv | 20 ++
 rtl/convert_64_8.sv | 88 ++++++++
 2 files changed

// File: rtl/convert_64_8_if.sv
// Word-in / byte-out handshake bundle for the 64->8 serializer.
// The master drives the word and downstream ready; the slave (the serializer) answers.
interface convert_64_8_if;
    logic [63:0] i_data;
    logic        i_rval;
    logic        o_rrdy;
    logic [7:0]  o_data;
    logic        o_tval;
    logic        i_trdy;

    modport master (
        output i_data, i_rval, i_trdy,
        input  o_rrdy, o_data, o_tval
    );

    modport slave (
        input  i_data, i_rval, i_trdy,
        output o_rrdy, o_data, o_tval
    );
endinterface

// File: rtl/convert_64_8.sv
// 64-bit word to 8-bit byte serializer; one word in, eight bytes out, no overlap.
// state | meaning
// IDLE  | ready for a word, no byte valid
// TX    | presenting bytes of the held word, input blocked
module convert_64_8 #(
    parameter int MSB_FIRST = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    convert_64_8_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TX   = 2'b01
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_count, w_count_nxt;
    logic [63:0] r_word,  w_word_nxt;
    logic        r_tval,  w_tval_nxt;
    logic        r_rrdy,  w_rrdy_nxt;
    logic        w_ixfer, w_oxfer;
    logic [2:0]  w_sel;

    assign w_ixfer = bus.i_rval & r_rrdy;
    assign w_oxfer = r_tval & bus.i_trdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= 3'd0;
            r_word  <= 64'd0;
            r_tval  <= 1'b0;
            r_rrdy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_word  <= w_word_nxt;
            r_tval  <= w_tval_nxt;
            r_rrdy  <= w_rrdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_word_nxt  = r_word;
        w_tval_nxt  = r_tval;
        w_rrdy_nxt  = r_rrdy;
        case (r_state)
            IDLE: begin
                if (w_ixfer) begin
                    w_word_nxt  = bus.i_data;
                    w_count_nxt = 3'd0;
                    w_tval_nxt  = 1'b1;
                    w_rrdy_nxt  = 1'b0;
                    w_state_nxt = TX;
                end
            end
            TX: begin
                if (w_oxfer) begin
                    if (r_count == 3'd7) begin
                        w_count_nxt = 3'd0;
                        w_tval_nxt  = 1'b0;
                        w_rrdy_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_count_nxt = r_count + 3'd1;
                    end
                end
            end
            // Unused encodings drop any partial word and reopen the input.
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = 3'd0;
                w_tval_nxt  = 1'b0;
                w_rrdy_nxt  = 1'b1;
            end
        endcase
    end

    assign w_sel      = (MSB_FIRST != 0) ? (3'd7 - r_count) : r_count;
    assign bus.o_data = r_word[{w_sel, 3'b000} +: 8];
    assign bus.o_tval = r_tval;
    assign bus.o_rrdy = r_rrdy;

endmodule
